// File: rtl/sr_lfsr_engine.sv
// sr_lfsr_engine
//   Scrambles one data word from the DDR traffic generator. Each accepted
//   word receives STEPS bit-serial Galois LFSR steps:
//     x_next = {x[W-2:0],1'b0} ^ (x[W-1] ? POLY : 0)
//   The result appears on sr_dout, qualified by sr_done.
//
// Ports
//   clk        sole clock
//   rst        asynchronous reset, active low
//   sr_bypass  (SR_BYPASS_EN only) with sr_newd: skip the LFSR and pass sr_din through
//   sr_din     input word
//   sr_newd    input word valid, level sampled in IDLE/DONE
//   sr_dout    scrambled result, held until the next result is ready
//   sr_done    result valid (DONE state)
//   sr_busy    high while shifting
//   op_cnt     count of completed words, wraps
//
// Optional build macro: SR_BYPASS_EN adds the sr_bypass port.
module sr_lfsr_engine #(
  parameter int APP_DATA_WIDTH = 64,
  parameter int STEPS          = 8,
  parameter logic [APP_DATA_WIDTH-1:0] POLY = 'h1B
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef SR_BYPASS_EN
  input  logic                      sr_bypass,
`endif
  input  logic [APP_DATA_WIDTH-1:0] sr_din,
  input  logic                      sr_newd,
  output logic [APP_DATA_WIDTH-1:0] sr_dout,
  output logic                      sr_done,
  output logic                      sr_busy,
  output logic [15:0]               op_cnt
);

  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t                    state, state_nxt;
  logic [APP_DATA_WIDTH-1:0] sreg;
  logic [CW-1:0]             cnt;
  logic                      accept, last_step, byp;

  function automatic logic [APP_DATA_WIDTH-1:0] lfsr_step(input logic [APP_DATA_WIDTH-1:0] x);
    lfsr_step = {x[APP_DATA_WIDTH-2:0], 1'b0} ^ (x[APP_DATA_WIDTH-1] ? POLY : '0);
  endfunction

`ifdef SR_BYPASS_EN
  assign byp = sr_bypass;
`else
  assign byp = 1'b0;
`endif

  // A new word may only be taken when not shifting; sr_newd is ignored in SHIFT.
  assign accept    = sr_newd && (state == IDLE || state == DONE);
  assign last_step = (cnt == CW'(STEPS - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (sr_newd) state_nxt = byp ? DONE : SHIFT;
      SHIFT:      if (last_step) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    sr_done = 1'b0;
    sr_busy = 1'b0;
    case (state)
      SHIFT:   sr_busy = 1'b1;
      DONE:    sr_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: shift register, step counter, result and completion count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg    <= '0;
      cnt     <= '0;
      sr_dout <= '0;
      op_cnt  <= '0;
    end else if (accept) begin
      sreg <= sr_din;
      cnt  <= '0;
      if (byp) begin
        sr_dout <= sr_din;
        op_cnt  <= op_cnt + 16'd1;
      end
    end else if (state == SHIFT) begin
      sreg <= lfsr_step(sreg);
      cnt  <= cnt + CW'(1);
      // sr_dout only moves on entry to DONE, so the last result stays visible.
      if (last_step) begin
        sr_dout <= lfsr_step(sreg);
        op_cnt  <= op_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sr_lfsr_engine.sv
// Self-checking bench for sr_lfsr_engine. Main instance uses the default
// parameters (STEPS=8); a second instance checks the STEPS=1 boundary.
module tb_sr_lfsr_engine;
  localparam int W     = 64;
  localparam int STEPS = 8;
  localparam logic [W-1:0] POLY = 64'h1B;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  sr_din = '0;
  logic          sr_newd = 1'b0;
  logic [W-1:0]  sr_dout, dout1;
  logic          sr_done, sr_busy, done1, busy1;
  logic [15:0]   op_cnt, ops1;
`ifdef SR_BYPASS_EN
  logic          sr_bypass = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sr_lfsr_engine #(.APP_DATA_WIDTH(W), .STEPS(STEPS), .POLY(POLY)) dut (
    .clk(clk), .rst(rst),
`ifdef SR_BYPASS_EN
    .sr_bypass(sr_bypass),
`endif
    .sr_din(sr_din), .sr_newd(sr_newd), .sr_dout(sr_dout),
    .sr_done(sr_done), .sr_busy(sr_busy), .op_cnt(op_cnt)
  );

  sr_lfsr_engine #(.APP_DATA_WIDTH(W), .STEPS(1), .POLY(POLY)) dut1 (
    .clk(clk), .rst(rst),
`ifdef SR_BYPASS_EN
    .sr_bypass(sr_bypass),
`endif
    .sr_din(sr_din), .sr_newd(sr_newd), .sr_dout(dout1),
    .sr_done(done1), .sr_busy(busy1), .op_cnt(ops1)
  );

  // Reference: n applications of the Galois step, as plain arithmetic.
  function automatic logic [W-1:0] ref_scramble(input logic [W-1:0] x, input int n);
    logic [W-1:0] v = x;
    for (int k = 0; k < n; k++) begin
      if (v[W-1]) v = (v << 1) ^ POLY;
      else        v = v << 1;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One cycle: inputs driven now are sampled at the next edge; outputs read #1 after it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    sr_newd = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (sr_done !== 1'b0 || sr_busy !== 1'b0 || sr_dout !== '0 || op_cnt !== 16'd0) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: done=%b busy=%b dout=%h ops=%0d, want 0/0/0/0", i, sr_done, sr_busy, sr_dout, op_cnt);
      end
      tick();
    end
    // Abort mid-SHIFT: reset asserted during cycle c+4.
    sr_din = rnd64(); sr_newd = 1'b1;
    tick();
    sr_newd = 1'b0;
    repeat (3) tick();
    tests++;
    if (sr_busy !== 1'b1) begin
      fails++; $display("FAIL abort_pre busy=%b want 1", sr_busy);
    end
    rst = 1'b0; #1;
    tests++;
    if (sr_done !== 1'b0 || sr_busy !== 1'b0 || sr_dout !== '0 || op_cnt !== 16'd0) begin
      fails++;
      $display("FAIL abort_async: done=%b busy=%b dout=%h ops=%0d, want all 0", sr_done, sr_busy, sr_dout, op_cnt);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      tests++;
      if (sr_done !== 1'b0 || sr_busy !== 1'b0) begin
        fails++; $display("FAIL abort_after cyc%0d: done=%b busy=%b want 0/0", i, sr_done, sr_busy);
      end
    end
  endtask

  task automatic run_single(input string name, input logic [W-1:0] din, input logic [W-1:0] want);
    do_reset();
    sr_din = din; sr_newd = 1'b1;
    tick();
    sr_newd = 1'b0; sr_din = rnd64();
    for (int i = 1; i <= STEPS; i++) begin
      tests++;
      if (sr_busy !== 1'b1 || sr_done !== 1'b0) begin
        fails++; $display("FAIL %s busy c+%0d: busy=%b done=%b want 1/0", name, i, sr_busy, sr_done);
      end
      tick();
    end
    tests++;
    if (sr_done !== 1'b1 || sr_busy !== 1'b0 || sr_dout !== want || op_cnt !== 16'd1) begin
      fails++;
      $display("FAIL %s result: done=%b busy=%b dout=%h ops=%0d want 1/0/%h/1", name, sr_done, sr_busy, sr_dout, op_cnt, want);
    end
    tests++;
    if (sr_dout !== ref_scramble(din, STEPS)) begin
      fails++; $display("FAIL %s model: dout=%h want %h", name, sr_dout, ref_scramble(din, STEPS));
    end
  endtask

  task automatic test_basic_shift();
    run_single("basic_shift", 64'h1, 64'h100);
  endtask

  task automatic test_feedback();
    run_single("feedback", 64'h8000_0000_0000_0000, 64'hD80);
    for (int r = 0; r < 3; r++) begin
      logic [W-1:0] d;
      d = rnd64();
      run_single("random_word", d, ref_scramble(d, STEPS));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] din, last_word;
    int next_accept;
    do_reset();
    din = rnd64();
    next_accept = 0;
    last_word = '0;
    sr_newd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tests++;
      if (i == next_accept) begin
        if (i > 0 && (sr_done !== 1'b1 || sr_dout !== ref_scramble(last_word, STEPS))) begin
          fails++;
          $display("FAIL b2b_done cyc%0d: done=%b dout=%h want 1/%h", i, sr_done, sr_dout, ref_scramble(last_word, STEPS));
        end
        last_word = din;
        next_accept = i + STEPS + 1;
      end else if (sr_done !== 1'b0 || sr_busy !== 1'b1) begin
        fails++; $display("FAIL b2b_shift cyc%0d: done=%b busy=%b want 0/1", i, sr_done, sr_busy);
      end
      sr_din = din;
      tick();
      din = din + 64'h10_0000;
    end
    sr_newd = 1'b0;
    tests++;
    if (op_cnt !== 16'd4) begin
      fails++; $display("FAIL b2b_opcnt: ops=%0d want 4", op_cnt);
    end
  endtask

  task automatic test_hold_done();
    logic [W-1:0] d;
    d = rnd64();
    do_reset();
    sr_din = d; sr_newd = 1'b1;
    tick();
    sr_newd = 1'b0;
    repeat (STEPS) tick();
    for (int i = 0; i < 30; i++) begin
      sr_din = rnd64();
      tests++;
      if (sr_done !== 1'b1 || sr_dout !== ref_scramble(d, STEPS) || op_cnt !== 16'd1) begin
        fails++;
        $display("FAIL hold cyc%0d: done=%b dout=%h ops=%0d want 1/%h/1", i, sr_done, sr_dout, op_cnt, ref_scramble(d, STEPS));
      end
      tick();
    end
    // Reset while in DONE clears everything.
    rst = 1'b0; #1;
    tests++;
    if (sr_done !== 1'b0 || sr_dout !== '0 || op_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_in_done: done=%b dout=%h ops=%0d want 0/0/0", sr_done, sr_dout, op_cnt);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_steps1();
    logic [W-1:0] d;
    d = rnd64();
    do_reset();
    sr_din = d; sr_newd = 1'b1;
    tick();
    sr_newd = 1'b0;
    tests++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      fails++; $display("FAIL steps1_shift: busy=%b done=%b want 1/0", busy1, done1);
    end
    tick();
    tests++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || dout1 !== ref_scramble(d, 1) || ops1 !== 16'd1) begin
      fails++;
      $display("FAIL steps1_result: done=%b busy=%b dout=%h ops=%0d want 1/0/%h/1", done1, busy1, dout1, ops1, ref_scramble(d, 1));
    end
  endtask

`ifdef SR_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    sr_din = 64'hDEAD_BEEF; sr_newd = 1'b1; sr_bypass = 1'b1;
    tick();
    sr_newd = 1'b0; sr_bypass = 1'b0;
    tests++;
    if (sr_done !== 1'b1 || sr_busy !== 1'b0 || sr_dout !== 64'hDEAD_BEEF || op_cnt !== 16'd1) begin
      fails++;
      $display("FAIL bypass: done=%b busy=%b dout=%h ops=%0d want 1/0/deadbeef/1", sr_done, sr_busy, sr_dout, op_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_shift();
    test_feedback();
    test_back_to_back();
    test_hold_done();
    test_steps1();
`ifdef SR_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end
endmodule
